// File: rtl/lsu.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned bus
// requests with byte enables, then aligns and extends the returned load data.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        r_we;

    logic        w_legal;
    logic        w_idle;
    logic        w_wait;
    logic        w_accept;
    logic        w_bad;
    logic        w_done;
    logic        w_tmo;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;

    // Size legality and natural alignment of the incoming request
    always_comb begin
        w_legal = 1'b0;
        case (core_size_i)
            SZ_B, SZ_BU: w_legal = 1'b1;
            SZ_H, SZ_HU: w_legal = ~core_addr_i[0];
            SZ_W:        w_legal = (core_addr_i[1:0] == 2'b00);
            default:     w_legal = 1'b0;
        endcase
    end

    assign w_idle    = (r_state == S_IDLE);
    assign w_wait    = (r_state == S_WAIT);
    assign w_accept  = ~rst_i & w_idle & core_req_i & w_legal;
    assign w_bad     = ~rst_i & w_idle & core_req_i & ~w_legal;
    assign w_done    = ~rst_i & w_wait & mem_ready_i;
    assign w_cnt_nxt = r_cnt + 16'd1;

    // A response arriving in the timeout cycle wins over the fault
    assign w_tmo = ~rst_i & w_wait & ~mem_ready_i
                 & (TO_LIM != 16'd0) & (w_cnt_nxt == TO_LIM);

    // Store lane placement; BU/HU share the B/H lane patterns
    always_comb begin
        w_be = 4'b0000;
        w_wd = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                w_be = 4'b0001 << core_addr_i[1:0];
                w_wd = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                w_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = core_wd_i;
            end
        endcase
    end

    assign w_shift = mem_rd_i >> {r_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        w_ld = mem_rd_i;
        case (r_size)
            SZ_B:    w_ld = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   w_ld = {24'd0, w_byte};
            SZ_H:    w_ld = {{16{w_half[15]}}, w_half};
            SZ_HU:   w_ld = {16'd0, w_half};
            default: w_ld = mem_rd_i;
        endcase
    end

    assign mem_req_o    = w_accept;
    assign mem_we_o     = w_accept & core_we_i;
    assign mem_be_o     = w_accept ? w_be : 4'b0000;
    assign mem_addr_o   = {core_addr_i[31:2], 2'b00};
    assign mem_wd_o     = w_wd;
    assign fault_o      = w_bad | w_tmo;
    assign core_rd_o    = (w_done & ~r_we) ? w_ld : 32'd0;
    assign core_stall_o = w_accept
                        | (~rst_i & w_wait & ~mem_ready_i & ~w_tmo);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 16'd0;
                        r_size  <= core_size_i;
                        r_off   <= core_addr_i[1:0];
                        r_we    <= core_we_i;
                    end
                end
                S_WAIT: begin
                    if (mem_ready_i || w_tmo) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: lane placement, load extension, faults,
// timeout and reset abort, with hand-computed expectations.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_chk = 0;
    int n_err = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .fault_o      (fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge, then let inputs settle
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = a;
        core_wd_i   = wd;
        #1;
    endtask

    task automatic idle_in();
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
    endtask

    // complete a pending access with one-cycle slave latency
    task automatic respond(input logic [31:0] rd, input string tag,
                           input logic [31:0] exp);
        tick();
        idle_in();
        mem_ready_i = 1'b1;
        mem_rd_i    = rd;
        #1;
        chk({tag, "_stall"}, 32'(core_stall_o), 32'd0);
        chk({tag, "_rd"}, core_rd_o, exp);
        chk({tag, "_noreq"}, 32'(mem_req_o), 32'd0);
        tick();
        mem_ready_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        idle_in();
        tick();
        req(1'b1, 3'd2, 32'h8000_0000, 32'h1111_1111);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_flt", 32'(fault_o), 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        tick();
        rst_i = 1'b0;
        idle_in();

        // word store then word load
        req(1'b1, 3'd2, 32'h8000_0000, 32'h0000_A5A5);
        chk("sw_req", 32'(mem_req_o), 32'd1);
        chk("sw_we", 32'(mem_we_o), 32'd1);
        chk("sw_be", 32'(mem_be_o), 32'hF);
        chk("sw_wd", mem_wd_o, 32'h0000_A5A5);
        chk("sw_addr", mem_addr_o, 32'h8000_0000);
        chk("sw_stall", 32'(core_stall_o), 32'd1);
        respond(32'hDEAD_BEEF, "sw", 32'd0);
        req(1'b0, 3'd2, 32'h8000_0000, 32'h0);
        chk("lw_stall", 32'(core_stall_o), 32'd1);
        respond(32'h0000_A5A5, "lw", 32'h0000_A5A5);

        // byte loads at offset 3; inputs scrambled during WAIT
        req(1'b0, 3'd0, 32'h1000_0003, 32'h0);
        tick();
        req(1'b1, 3'd2, 32'h2000_0000, 32'hFFFF_FFFF);
        chk("lb_wait_noreq", 32'(mem_req_o), 32'd0);
        chk("lb_wait_stall", 32'(core_stall_o), 32'd1);
        respond(32'h80FF_1234, "lb", 32'hFFFF_FF80);
        req(1'b0, 3'd4, 32'h1000_0003, 32'h0);
        respond(32'h80FF_1234, "lbu", 32'h0000_0080);

        // half loads at offset 2
        req(1'b0, 3'd1, 32'h1000_0002, 32'h0);
        respond(32'h8001_1234, "lh", 32'hFFFF_8001);
        req(1'b0, 3'd5, 32'h1000_0002, 32'h0);
        respond(32'h8001_1234, "lhu", 32'h0000_8001);

        // half and byte stores
        req(1'b1, 3'd1, 32'h1000_0002, 32'h1234_BEEF);
        chk("sh_wd", mem_wd_o, 32'hBEEF_BEEF);
        chk("sh_be", 32'(mem_be_o), 32'b1100);
        chk("sh_addr", mem_addr_o, 32'h1000_0000);
        respond(32'h0, "sh", 32'd0);
        req(1'b1, 3'd0, 32'h1000_0001, 32'h0000_00AB);
        chk("sb_wd", mem_wd_o, 32'hABAB_ABAB);
        chk("sb_be", 32'(mem_be_o), 32'b0010);
        respond(32'h0, "sb", 32'd0);

        // ready while idle is ignored
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h1234_5678;
        #1;
        chk("idle_rdy_rd", core_rd_o, 32'd0);
        chk("idle_rdy_stall", 32'(core_stall_o), 32'd0);
        tick();
        mem_ready_i = 1'b0;

        // misaligned word and illegal size
        req(1'b0, 3'd2, 32'h1000_0002, 32'h0);
        chk("mis_flt", 32'(fault_o), 32'd1);
        chk("mis_req", 32'(mem_req_o), 32'd0);
        chk("mis_stall", 32'(core_stall_o), 32'd0);
        tick();
        idle_in();
        #1;
        chk("mis_flt_end", 32'(fault_o), 32'd0);
        req(1'b0, 3'd3, 32'h1000_0000, 32'h0);
        chk("sz3_flt", 32'(fault_o), 32'd1);
        chk("sz3_req", 32'(mem_req_o), 32'd0);
        tick();
        idle_in();

        // timeout: stall N..N+3, fault at N+4
        req(1'b0, 3'd2, 32'h3000_0000, 32'h0);
        chk("to_n_stall", 32'(core_stall_o), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            idle_in();
            #1;
            chk("to_wait_stall", 32'(core_stall_o), 32'd1);
            chk("to_wait_flt", 32'(fault_o), 32'd0);
        end
        tick();
        mem_rd_i = 32'hCAFE_F00D;
        #1;
        chk("to_flt", 32'(fault_o), 32'd1);
        chk("to_stall", 32'(core_stall_o), 32'd0);
        chk("to_rd", core_rd_o, 32'd0);
        tick();
        req(1'b0, 3'd2, 32'h3000_0000, 32'h0);
        chk("to_idle_req", 32'(mem_req_o), 32'd1);
        chk("to_idle_flt", 32'(fault_o), 32'd0);

        // ready in the timeout cycle counts as success
        for (int k = 1; k <= 3; k++) begin
            tick();
            idle_in();
        end
        respond(32'h0BAD_CAFE, "to_rdy", 32'h0BAD_CAFE);
        chk("to_rdy_flt", 32'(fault_o), 32'd0);

        // reset at N+2 aborts the access
        req(1'b0, 3'd2, 32'h3000_0000, 32'h0);
        tick();
        idle_in();
        tick();
        rst_i = 1'b1;
        #1;
        chk("abort_stall", 32'(core_stall_o), 32'd0);
        chk("abort_flt", 32'(fault_o), 32'd0);
        tick();
        rst_i = 1'b0;
        req(1'b0, 3'd2, 32'h3000_0000, 32'h0);
        chk("abort_idle_req", 32'(mem_req_o), 32'd1);
        chk("abort_idle_flt", 32'(fault_o), 32'd0);
        respond(32'h5555_AAAA, "abort_next", 32'h5555_AAAA);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the system data bus that feeds the peripheral controllers (LED, switches, UART) and data memory. Turns core byte/half/word loads and stores into word-aligned bus requests with byte enables, stalls the core until the addressed slave returns data, and aligns plus sign/zero-extends load data. Also flags misaligned or illegal accesses and bus timeouts.

## Interface
- TIMEOUT, 255: max cycles spent in WAIT before fault; 0 disables the timeout; legal range 0..65535
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  1  core requests a memory access this cycle
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU; 3, 6, 7 illegal
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  load result, extended
- core_stall_o  out  1  core must hold its inputs and not retire
- fault_o  out  1  one-cycle pulse: misaligned, illegal size, or timeout
- mem_req_o  out  1  bus request, one-cycle pulse per access
- mem_we_o  out  1  bus write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  {core_addr_i[31:2], 2'b00}
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  slave read data
- mem_ready_i  in  1  slave response valid, at least 1 cycle after mem_req_o

## Operation
- FSM states: IDLE, WAIT. Reset state is IDLE.
- Alignment check in IDLE when core_req_i = 1:
  - Legal: W with addr[1:0] = 0; H/HU with addr[0] = 0; B/BU any address.
  - An illegal size code is a fault.
- IDLE, core_req_i = 1, access legal:
  - mem_req_o = 1 (combinational) and core_stall_o = 1.
  - Latch size and addr[1:0]; next state WAIT.
- IDLE, core_req_i = 1, access not legal:
  - fault_o = 1 and mem_req_o = 0, core_stall_o = 0.
  - Stay in IDLE.
- WAIT, mem_ready_i = 1:
  - core_stall_o = 0 and core_rd_o is valid (combinational from mem_rd_i) in that same cycle.
  - Next state IDLE.
- WAIT, mem_ready_i = 0:
  - core_stall_o = 1 and the 16-bit wait counter increments.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT: fault_o = 1, core_stall_o = 0, core_rd_o = 0, next state IDLE.
- Any mem_ready_i seen in IDLE is ignored.
- Store lanes, from addr[1:0]:
  - B: mem_wd_o = {4{wd[7:0]}}, mem_be_o = 4'b0001 << addr[1:0].
  - H: mem_wd_o = {2{wd[15:0]}}, mem_be_o = addr[1] ? 4'b1100 : 4'b0011.
  - W: mem_wd_o = wd, mem_be_o = 4'b1111.
- Load extraction uses the latched size and offset:
  - Select byte/half lane from mem_rd_i.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Stores also complete only on mem_ready_i. core_rd_o is 0 for stores.
- While mem_req_o = 0: mem_we_o = 0 and mem_be_o = 0.

## Timing
- Reset: state IDLE, wait counter 0.
- In reset cycles every output is 0: core_stall_o, fault_o, mem_req_o, mem_we_o, mem_be_o, core_rd_o.
- rst_i during WAIT aborts the access: next cycle IDLE, no fault, no stall.
- Minimum access is 2 cycles:
  - Cycle N: request issued, stall.
  - Cycle N+1: mem_ready_i, data returned, core retires.
- Back-to-back accesses: a new request is accepted in the cycle after completion (IDLE), so throughput is one access per 2 cycles.
- Exactly one mem_req_o pulse per accepted access, never repeated during WAIT. This is required because slave writes such as a reset register have side effects.
- Core inputs may change during WAIT without effect. Only latched size and offset are used.
- Timeout with TIMEOUT = T: the fault pulse occurs in the T-th WAIT cycle without mem_ready_i, i.e. cycle N+T.
- mem_ready_i arriving together with the timeout cycle counts as success: no fault.

## Test plan
- Word store then load, addr 0x80000000, wd 0x0000A5A5, slave ready 1 cycle after req:
  - mem_be_o = 4'hF, one mem_req_o pulse, stall for exactly 1 cycle.
  - The load returns 0x0000A5A5 at N+1.
- Byte load, addr 0x…03, mem_rd_i = 0x80FF1234:
  - B gives 0xFFFFFF80; BU gives 0x00000080.
- Half load, addr 0x…02, mem_rd_i = 0x8001xxxx:
  - H gives 0xFFFF8001; HU gives 0x00008001.
- Half store, addr 0x…02, wd 0x1234BEEF:
  - mem_wd_o = 0xBEEFBEEF, mem_be_o = 4'b1100, mem_addr_o low bits 00.
- Word load at addr 0x…02, and size code 3:
  - fault_o = 1 for one cycle, no mem_req_o, no stall.
- TIMEOUT = 4, slave never ready:
  - Stall for cycles N..N+3, then fault_o at N+4 and return to IDLE.
  - Repeat with rst_i asserted at N+2: IDLE at N+3, no fault.
